// File: rtl/hub75_pkg.sv
// Shared sizing for the HUB75 framebuffer path.
package hub75_pkg;

    localparam int unsigned BITS_PER_PIXEL = 32;
    localparam int unsigned COL_BITS       = 6;
    localparam int unsigned ROW_BITS       = 5;
    localparam int unsigned FB_ADDR_W      = 1 + ROW_BITS + COL_BITS;

endpackage

// File: rtl/strobe_sync.sv
// Three-flop synchroniser for an asynchronous strobe with a rising-edge pulse output.
// The chain presets to 1 so a strobe held high through reset release gives no pulse.
module strobe_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic strobe_i,
    output logic pulse_o
);

    // sync_q[0] = s1, sync_q[1] = s2, sync_q[2] = s3
    logic [2:0] sync_q;

    // Shift the async strobe through the synchroniser chain.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= 3'b111;
        end else begin
            sync_q <= {sync_q[1:0], strobe_i};
        end
    end

    // Rising edge seen on the synchronised strobe.
    always_comb begin
        pulse_o = sync_q[1] & ~sync_q[2];
    end

endmodule

// File: rtl/framebuffer_writer.sv
// Writes synchronised pixel words into a double-buffered framebuffer, stepping a
// {row,col} pointer and swapping banks at the end of each frame.
module framebuffer_writer
    import hub75_pkg::*;
#(
    parameter int unsigned BITS_PER_PIXEL = hub75_pkg::BITS_PER_PIXEL,
    parameter int unsigned COL_BITS       = hub75_pkg::COL_BITS,
    parameter int unsigned ROW_BITS       = hub75_pkg::ROW_BITS
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [BITS_PER_PIXEL-1:0]          data,
    input  logic                               pixel_clk,
    input  logic                               sof,
    output logic                               fb_we,
    output logic [ROW_BITS+COL_BITS:0]         fb_addr,
    output logic [BITS_PER_PIXEL-1:0]          fb_data,
    output logic                               frame_done,
    output logic                               display_bank
);

    localparam int unsigned PTR_W = ROW_BITS + COL_BITS;

    logic                      pixel_edge;
    // Pointer is {row,col}; a plain increment carries col wrap into row.
    logic [PTR_W-1:0]          ptr_q, ptr_d;
    logic [PTR_W-1:0]          base;
    logic                      write_bank_q, write_bank_d;
    logic                      display_bank_d;
    logic                      fb_we_d;
    logic                      frame_done_d;
    logic [PTR_W:0]            fb_addr_d;
    logic [BITS_PER_PIXEL-1:0] fb_data_d;

    strobe_sync u_pixel_sync (
        .clk_i    (clk),
        .rst_i    (reset),
        .strobe_i (pixel_clk),
        .pulse_o  (pixel_edge)
    );

    // Next-state for pointer, banks and the registered write port.
    always_comb begin
        ptr_d          = ptr_q;
        write_bank_d   = write_bank_q;
        display_bank_d = display_bank;
        fb_we_d        = 1'b0;
        frame_done_d   = 1'b0;
        fb_addr_d      = fb_addr;
        fb_data_d      = fb_data;
        // A last-pixel write wins over sof so the frame still completes and swaps.
        base           = (sof && !(&ptr_q)) ? '0 : ptr_q;

        if (pixel_edge) begin
            fb_we_d   = 1'b1;
            fb_data_d = data;
            fb_addr_d = {write_bank_q, base};
            if (&base) begin
                frame_done_d   = 1'b1;
                ptr_d          = '0;
                write_bank_d   = ~write_bank_q;
                display_bank_d = write_bank_q;
            end else begin
                ptr_d = base + 1'b1;
            end
        end else if (sof) begin
            ptr_d = '0;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q        <= '0;
            write_bank_q <= 1'b0;
            display_bank <= 1'b1;
            fb_we        <= 1'b0;
            frame_done   <= 1'b0;
            fb_addr      <= '0;
            fb_data      <= '0;
        end else begin
            ptr_q        <= ptr_d;
            write_bank_q <= write_bank_d;
            display_bank <= display_bank_d;
            fb_we        <= fb_we_d;
            frame_done   <= frame_done_d;
            fb_addr      <= fb_addr_d;
            fb_data      <= fb_data_d;
        end
    end

endmodule
